// File: rtl/seq_divider_pkg.sv
// div_pkg: types and defaults shared by the sequential divider.
//   state_t       - FSM state encoding (IDLE, RUN, DONE) on 2 bits
//   DEFAULT_WIDTH - default operand/result width
package div_pkg;
    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/seq_divider_step.sv
// div_step: one combinational restoring-division iteration.
//   rem      in  WIDTH  partial remainder before this step
//   in_bit   in  1      next dividend bit, shifted into the remainder LSB
//   divisor  in  WIDTH  divisor
//   rem_next out WIDTH  partial remainder after this step
//   q_bit    out 1      quotient bit produced by this step
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             in_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);
    // The remainder's top bit is always 0 before a shift (rem < 2^k after k
    // steps, and the full-width value only appears after the final step), so
    // keeping it in the WIDTH+1-bit shifted value equals the WIDTH-bit shift.
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        shifted  = {rem, in_bit};
        diff     = shifted - {1'b0, divisor};
        q_bit    = ~diff[WIDTH];
        rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end
endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider, one step per cycle.
//   clk, rst_n            clock (rising edge), async active-low reset
//   start                 request, sampled only in IDLE with the operands
//   dividend, divisor     unsigned operands
//   busy                  high while iterating
//   done                  one-cycle pulse, results valid
//   quotient, remainder   registered results, held until the next result
//   div_by_zero           set with done when the divisor was 0
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] dq;       // dividend shifts out the top, quotient shifts in
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;
    logic             dz_pend;  // divide-by-zero accepted, result due next edge

    logic [WIDTH-1:0] rem_next;
    logic             q_bit;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .in_bit   (dq[WIDTH-1]),
        .divisor  (dvs),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            dq          <= '0;
            dvs         <= '0;
            rem         <= '0;
            dz_pend     <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Divide-by-zero spends one idle cycle so its done pulse
                    // lands one cycle after the accepting edge; start is
                    // ignored meanwhile.
                    if (dz_pend) begin
                        quotient    <= '1;
                        remainder   <= dq;
                        div_by_zero <= 1'b1;
                        dz_pend     <= 1'b0;
                        state       <= DONE;
                    end else if (start) begin
                        cnt <= '0;
                        dq  <= dividend;
                        dvs <= divisor;
                        rem <= '0;
                        if (divisor == '0) dz_pend <= 1'b1;
                        else               state   <= RUN;
                    end
                end
                RUN: begin
                    rem <= rem_next;
                    dq  <= {dq[WIDTH-2:0], q_bit};
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH-1)) begin
                        quotient    <= {dq[WIDTH-2:0], q_bit};
                        remainder   <= rem_next;
                        div_by_zero <= 1'b0;
                        state       <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    int nchk = 0;
    int npass = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    // Issue one op and wait for done. lat = edges from accept to done,
    // bcnt = cycles busy seen, stable = results unchanged before done,
    // wide1 = done dropped after one cycle.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output int bcnt, output bit stable,
                          output bit wide1, output bit both);
        logic [W-1:0] pq, pr;
        logic         pz;
        pq = quotient; pr = remainder; pz = div_by_zero;
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; bcnt = 0; stable = 1'b1; both = 1'b0;
        while (!done && lat < 100) begin
            if (busy) bcnt++;
            if (quotient !== pq || remainder !== pr || div_by_zero !== pz) stable = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (busy && done) both = 1'b1;
        if (lat >= 100) chk("timeout", 32'(lat), 32'd0);
        pq = quotient; pr = remainder; pz = div_by_zero;
        @(posedge clk); #1;
        wide1 = !done;
        if (quotient !== pq || remainder !== pr || div_by_zero !== pz) stable = 1'b0;
    endtask

    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic edz, input int elat, input int ebusy);
        int lat, bcnt;
        bit stable, wide1, both;
        run_op(a, b, lat, bcnt, stable, wide1, both);
        chk({tag, ".lat"}, 32'(lat), 32'(elat));
        chk({tag, ".busy_cycles"}, 32'(bcnt), 32'(ebusy));
        chk({tag, ".q"}, 32'(quotient), 32'(eq));
        chk({tag, ".r"}, 32'(remainder), 32'(er));
        chk({tag, ".dz"}, 32'(div_by_zero), 32'(edz));
        chk({tag, ".done_1cyc"}, 32'(wide1), 32'd1);
        chk({tag, ".stable"}, 32'(stable), 32'd1);
        chk({tag, ".busy_and_done"}, 32'(both), 32'd0);
    endtask

    initial begin
        int lat, bcnt, k;
        bit stable, wide1, both;
        logic [W-1:0] a, b;

        // reset state
        #1;
        chk("rst.busy", 32'(busy), 0);
        chk("rst.done", 32'(done), 0);
        chk("rst.q", 32'(quotient), 0);
        chk("rst.r", 32'(remainder), 0);
        chk("rst.dz", 32'(div_by_zero), 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);

        do_op("100/7", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 16, 16);
        do_op("ffff/1", 16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, 16, 16);
        do_op("ffff/ffff", 16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0, 16, 16);
        do_op("3/10", 16'd3, 16'd10, 16'd0, 16'd3, 1'b0, 16, 16);
        do_op("5/0", 16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1, 1, 0);
        do_op("ffff/8001", 16'hFFFF, 16'h8001, 16'd1, 16'h7FFE, 1'b0, 16, 16);
        do_op("dz_clear", 16'd7, 16'd7, 16'd1, 16'd0, 1'b0, 16, 16);

        // start re-pulsed during RUN and during DONE must be ignored
        @(negedge clk); start = 1'b1; dividend = 16'd1000; divisor = 16'd3;
        @(posedge clk); #1; start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk); start = 1'b1; dividend = 16'd9; divisor = 16'd9;
        @(posedge clk); #1; start = 1'b0;
        k = 0;
        while (!done && k < 100) begin @(posedge clk); #1; k++; end
        chk("ign.lat", 32'(k + 5), 32'd16);
        chk("ign.q", 32'(quotient), 32'd333);
        chk("ign.r", 32'(remainder), 32'd1);
        start = 1'b1;               // held across the DONE edge
        @(posedge clk); #1; start = 1'b0;
        k = 0;
        repeat (3) begin @(posedge clk); #1; if (busy || done) k++; end
        chk("ign.no_restart", 32'(k), 32'd0);
        chk("ign.q_hold", 32'(quotient), 32'd333);
        do_op("9/9", 16'd9, 16'd9, 16'd1, 16'd0, 1'b0, 16, 16);

        // back-to-back throughput: start held high, second accept at k+W+2
        @(negedge clk); start = 1'b1; dividend = 16'd20; divisor = 16'd3;
        k = 0;
        @(posedge clk); #1;
        while (!done && k < 100) begin @(posedge clk); #1; k++; end
        k = 0;
        while (!busy && k < 100) begin @(posedge clk); #1; k++; end
        start = 1'b0;
        chk("b2b.gap", 32'(k), 32'd2);
        k = 0;
        while (!done && k < 100) begin @(posedge clk); #1; k++; end
        chk("b2b.q", 32'(quotient), 32'd6);
        chk("b2b.r", 32'(remainder), 32'd2);
        @(posedge clk); #1;

        // asynchronous reset in the middle of RUN
        @(negedge clk); start = 1'b1; dividend = 16'd100; divisor = 16'd7;
        @(posedge clk); #1; start = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst.busy", 32'(busy), 0);
        chk("mid_rst.done", 32'(done), 0);
        chk("mid_rst.q", 32'(quotient), 0);
        chk("mid_rst.r", 32'(remainder), 0);
        chk("mid_rst.dz", 32'(div_by_zero), 0);
        @(negedge clk); rst_n = 1'b1;
        do_op("50/6", 16'd50, 16'd6, 16'd8, 16'd2, 1'b0, 16, 16);

        // random operands: invariant and done width
        for (int i = 0; i < 60; i++) begin
            a = 16'($urandom);
            b = 16'($urandom_range(1, 65535));
            if (i % 3 == 0) b = 16'($urandom_range(1, 255));
            run_op(a, b, lat, bcnt, stable, wide1, both);
            chk("rnd.recon", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
            chk("rnd.r_lt_d", 32'(remainder < b), 32'd1);
            chk("rnd.done_1cyc", 32'({wide1, stable}), 32'd3);
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
